// File: rtl/imem_boot_ctrl_if.sv
// Loader-side valid/ready handshake carrying instruction words into
// imem_boot_ctrl. The loader is the master, the controller the slave.
interface imem_boot_ctrl_if;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_data;
    logic        ld_last;

    modport master (
        output ld_valid,
        output ld_data,
        output ld_last,
        input  ld_ready
    );

    modport slave (
        input  ld_valid,
        input  ld_data,
        input  ld_last,
        output ld_ready
    );
endinterface

// File: rtl/imem_boot_ctrl.sv
// Boot/reload controller for the instruction memory of the single-cycle core.
// Streams loader words into consecutive memory words starting at address 0,
// feeds NOPs to the core while loading, and releases the core once the final
// write has landed.
// Optional feature: define IMEM_CKSUM_EN to add an XOR checksum word after
// the last program word (CHK state); a mismatch ends in ERR.
module imem_boot_ctrl #(
    parameter int unsigned DEPTH    = 101,
    parameter int unsigned CNT_W    = 7,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               boot,
    input  logic               reload,
    imem_boot_ctrl_if.slave    ld,
    output logic               mem_we,
    output logic [31:0]        mem_waddr,
    output logic [31:0]        mem_wdata,
    input  logic [31:0]        imem_inst,
    output logic [31:0]        fetch_inst,
    output logic               core_run,
    output logic               load_err,
    output logic [CNT_W-1:0]   words_loaded
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_FIN  = 3'd2;
    localparam logic [2:0] S_RUN  = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;
`ifdef IMEM_CKSUM_EN
    localparam logic [2:0] S_CHK  = 3'd5;
`endif

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

    logic [2:0]       state;
    logic [2:0]       state_nx;
    logic [CNT_W-1:0] word_cnt;
    logic             beat;
    logic             load_beat;
    logic             enter_load;
    logic             enter_err;

`ifdef IMEM_CKSUM_EN
    logic [31:0]      cksum;
    assign ld.ld_ready = (state == S_LOAD) || (state == S_CHK);
`else
    assign ld.ld_ready = (state == S_LOAD);
`endif

    assign beat       = ld.ld_valid && ld.ld_ready;
    assign load_beat  = beat && (state == S_LOAD);
    assign enter_load = (state_nx == S_LOAD) && (state != S_LOAD);
    assign enter_err  = (state_nx == S_ERR) && (state != S_ERR);
    assign fetch_inst = core_run ? imem_inst : NOP_INST;

    // Next-state selection for the load sequencer
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (boot) state_nx = S_LOAD;
            S_LOAD: begin
                if (beat) begin
                    if (ld.ld_last) begin
`ifdef IMEM_CKSUM_EN
                        state_nx = S_CHK;
`else
                        state_nx = S_FIN;
`endif
                    end else if (word_cnt == LAST_IDX) begin
                        state_nx = S_ERR;
                    end
                end
            end
`ifdef IMEM_CKSUM_EN
            S_CHK:  if (beat) state_nx = (ld.ld_data == cksum) ? S_FIN : S_ERR;
`endif
            S_FIN:  state_nx = S_RUN;
            S_RUN:  if (reload) state_nx = S_LOAD;
            S_ERR:  if (reload) state_nx = S_LOAD;
            default: state_nx = S_IDLE;
        endcase
    end

    // State register; core_run tracks RUN exactly, one register stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            core_run <= 1'b0;
        end else begin
            state    <= state_nx;
            core_run <= (state_nx == S_RUN);
        end
    end

    // Memory write port: one-cycle write pulse per accepted program word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= load_beat;
            if (load_beat) begin
                mem_waddr <= 32'({word_cnt, 2'b00});
                mem_wdata <= ld.ld_data;
            end
        end
    end

    // Word counter: cleared on every entry to LOAD, bumped per written word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt <= '0;
        end else if (enter_load) begin
            word_cnt <= '0;
        end else if (load_beat) begin
            word_cnt <= word_cnt + 1'b1;
        end
    end

    // Load status: error flag and size of the last completed program
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_err     <= 1'b0;
            words_loaded <= '0;
        end else begin
            if (enter_load) begin
                load_err <= 1'b0;
            end else if (enter_err) begin
                load_err <= 1'b1;
            end
            if (load_beat && ld.ld_last) begin
                words_loaded <= word_cnt + 1'b1;
            end
        end
    end

`ifdef IMEM_CKSUM_EN
    // XOR of all program words; the checksum word itself is not folded in
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cksum <= '0;
        end else if (enter_load) begin
            cksum <= '0;
        end else if (load_beat) begin
            cksum <= cksum ^ ld.ld_data;
        end
    end
`endif

endmodule
